timer_irq_source: RTL and testbench
===================================

Name: timer_irq_source

Overview:
Memory-mapped interval timer that drives the CPU fetch stage's interrupt input.
- Software programs reload (TH), counter (TL) and control/status (TCON) through the data-memory bus.
- On counter overflow it raises a level interrupt that stays asserted until software clears it.
- The fetch stage masks it while PC[31] (kernel mode) is set.

Parameters:
BASE_ADDR, 32'h40000000, byte base address of the register window; bits [3:0] must be zero.
PRESCALE, 1, clocks per counter tick; legal range 1..65535.

Ports:
clk  input  1  system clock
reset  input  1  system reset
iAddr  input  32  data-bus byte address
iWriteData  input  32  data-bus write data
iMemWrite  input  1  write strobe, sampled on posedge clk
iMemRead  input  1  read strobe
oReadData  output  32  read data, combinational
oIrq  output  1  level interrupt request to the fetch stage's interrupt input

Behaviour:
- Reset: asynchronous, active-high, on signal reset; clock clk, all state on posedge clk.
- Reset values: TH=0, TL=0, TCON=0, prescaler=0. oIrq=0 immediately on reset assertion, without waiting for a clock edge. oReadData=0.
- Decode: hit when iAddr[31:4]==BASE_ADDR[31:4]. iAddr[3:2] selects 0=TH, 1=TL, 2=TCON, 3=reserved. iAddr[1:0] ignored.
- Unmapped or reserved reads return 0; writes to them are ignored.
- oReadData: the selected register when iMemRead is high and the address hits; 0 otherwise.
- TCON bits:
  - bit0 EN, counter enable.
  - bit1 IE, interrupt enable.
  - bit2 ST, overflow status.
  - bits31:3 read 0 and ignore writes.
- Prescaler, 16-bit:
  - While EN=1, counts 0..PRESCALE-1; a tick occurs in the cycle where prescaler==PRESCALE-1, and the prescaler then wraps to 0.
  - While EN=0, the prescaler is forced to 0 and no ticks occur.
- Tick actions:
  - If TL==32'hFFFFFFFF: TL<=TH (reload), and ST<=1 if IE=1.
  - Otherwise: TL<=TL+1 (32-bit modular).
- Enable timing: tick and overflow evaluation use register values before any same-cycle write. A write that clears EN takes effect from the next cycle.
- oIrq = IE & ST, decoded from registers. It rises in the cycle after the overflow edge and is level-held, not pulsed.
- ST is cleared only by a TCON write with bit2=0. Writing bit2=1 sets ST, which software uses for self-test.
- Same-edge collisions:
  - TCON write + overflow: bits 1:0 take the write data; ST = wd[2] | (overflow & old IE), so an interrupt is never lost.
  - TL write + tick: the write wins; no increment or reload that cycle, and no ST set.
  - TH write + reload: TL reloads the old TH value.
- Clearing IE while ST=1 drops oIrq next cycle; ST is retained, so setting IE again re-asserts oIrq.
- Mid-operation reset: asynchronously clears all state. The counter resumes only after software re-enables it.

Optional Feature:
TIMER_SYSTICK_EN
- Defined: adds a read-only SYSTICK register at offset 0x0C.
  - 32-bit free-running count of clk edges since reset; wraps at 2^32.
  - Not gated by EN; writes ignored; reset value 0.
- Undefined: offset 0x0C is reserved, reads 0, and no SYSTICK register is present.

Test Plan:
- Reset then read TH, TL, TCON (and 0x0C) -> all 0, oIrq=0; read 0x40000010 -> 0.
- PRESCALE=1; write TH=0xFFFFFFF0, TL=0xFFFFFFFD, TCON=3 -> TL reads 0xFFFFFFFE, 0xFFFFFFFF, then 0xFFFFFFF0. TCON reads 7 and oIrq=1 from the cycle after reload, and holds for 100+ cycles.
- With oIrq=1, write TCON=3 -> oIrq=0 next cycle. Counting continues; the next overflow occurs 16 ticks after the previous reload.
- TCON=2 written on the same edge as overflow (IE=1 beforehand) -> TCON reads 6, oIrq=1, TL=TH, counter stopped afterwards.
- IE=0, EN=1, overflow -> TL reloads, TCON reads 1, oIrq stays 0. With PRESCALE=4, TL advances once every 4 clocks.
- Assert reset asynchronously mid-count with oIrq=1 -> oIrq falls before the next clk edge; TL=0 and TCON=0 after release.

Source files
------------

// File: rtl/timer_irq_source.sv
// timer_irq_source: memory-mapped interval timer (TH/TL/TCON) driving a level IRQ; define TIMER_SYSTICK_EN to add the read-only SYSTICK counter at offset 0x0C
module timer_irq_source #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWriteData,
    input  logic        iMemWrite,
    input  logic        iMemRead,
    output logic [31:0] oReadData,
    output logic        oIrq
);
    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [31:0] th, tl, slot3;
    logic        en, ie, st;
    logic [15:0] pre;
    logic        hit, wr_th, wr_tl, wr_tcon, tick, ovf;
    logic [1:0]  sel;
    logic        unused;

    assign unused  = &{1'b0, iAddr[1:0]};
    assign hit     = iAddr[31:4] == BASE_ADDR[31:4];
    assign sel     = iAddr[3:2];
    assign wr_th   = iMemWrite && hit && sel == 2'd0;
    assign wr_tl   = iMemWrite && hit && sel == 2'd1;
    assign wr_tcon = iMemWrite && hit && sel == 2'd2;
    assign tick    = en && pre == PRE_LAST;
    assign ovf     = tick && tl == 32'hFFFF_FFFF;
    assign oIrq    = ie & st;

    // Prescaler runs 0..PRESCALE-1 while enabled and is held at zero otherwise
    always_ff @(posedge clk or posedge reset)
        if (reset) pre <= '0;
        else       pre <= (!en || tick) ? '0 : pre + 16'd1;

    // Reload and counter; a TL write beats the tick, reload takes the pre-write TH
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            th <= '0;
            tl <= '0;
        end else begin
            if (wr_th) th <= iWriteData;
            if (wr_tl)     tl <= iWriteData;
            else if (tick) tl <= ovf ? th : tl + 32'd1;
        end

    // Control/status; an overflow on the same edge as a TCON write still latches ST
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            en <= 1'b0;
            ie <= 1'b0;
            st <= 1'b0;
        end else if (wr_tcon) begin
            en <= iWriteData[0];
            ie <= iWriteData[1];
            st <= iWriteData[2] | (ovf & ie);
        end else if (ovf && ie && !wr_tl) begin
            st <= 1'b1;
        end

`ifdef TIMER_SYSTICK_EN
    logic [31:0] systick;

    // Free-running clock-edge count since reset, independent of EN
    always_ff @(posedge clk or posedge reset)
        if (reset) systick <= '0;
        else       systick <= systick + 32'd1;

    assign slot3 = systick;
`else
    assign slot3 = '0;
`endif

    assign oReadData = !(iMemRead && hit) ? '0 :
                       sel == 2'd0 ? th :
                       sel == 2'd1 ? tl :
                       sel == 2'd2 ? {29'b0, st, ie, en} : slot3;
endmodule

// File: tb/tb_timer_irq_source.sv
// tb_timer_irq_source: directed and randomized checks of two timer instances (PRESCALE 1 and 4) against a reference model
module tb_timer_irq_source;
    localparam logic [31:0] BASE = 32'h40000000;
    localparam int PS4 = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wd, rd0, rd4;
    logic        we, re, irq0, irq4;
    int          n_pass = 0, n_total = 0;

    logic [31:0] m_th[2], m_tl[2], m_sys;
    logic        m_en[2], m_ie[2], m_st[2];
    int          m_k[2];

    timer_irq_source #(.BASE_ADDR(BASE), .PRESCALE(1)) u0 (
        .clk(clk), .reset(reset), .iAddr(addr), .iWriteData(wd),
        .iMemWrite(we), .iMemRead(re), .oReadData(rd0), .oIrq(irq0));

    timer_irq_source #(.BASE_ADDR(BASE), .PRESCALE(PS4)) u4 (
        .clk(clk), .reset(reset), .iAddr(addr), .iWriteData(wd),
        .iMemWrite(we), .iMemRead(re), .oReadData(rd4), .oIrq(irq4));

    always #50 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_th[i] = 0; m_tl[i] = 0; m_en[i] = 0; m_ie[i] = 0; m_st[i] = 0; m_k[i] = 0;
        end
        m_sys = 0;
    endtask

    // Ticks happen on every PRESCALE-th consecutive enabled cycle
    task automatic step_model();
        logic hit, tick, ovf, w_th, w_tl, w_tc;
        int p;
        hit  = addr[31:4] == BASE[31:4];
        w_th = we && hit && addr[3:2] == 2'd0;
        w_tl = we && hit && addr[3:2] == 2'd1;
        w_tc = we && hit && addr[3:2] == 2'd2;
        for (int i = 0; i < 2; i++) begin
            p    = (i == 0) ? 1 : PS4;
            tick = m_en[i] && (m_k[i] % p == p - 1);
            ovf  = tick && m_tl[i] == 32'hFFFFFFFF;
            m_k[i] = m_en[i] ? m_k[i] + 1 : 0;
            if (w_tl)      m_tl[i] = wd;
            else if (ovf)  m_tl[i] = m_th[i];
            else if (tick) m_tl[i] = m_tl[i] + 1;
            if (w_tc)                           m_st[i] = wd[2] | (ovf & m_ie[i]);
            else if (ovf && m_ie[i] && !w_tl)   m_st[i] = 1'b1;
            if (w_tc) begin
                m_en[i] = wd[0];
                m_ie[i] = wd[1];
            end
            if (w_th) m_th[i] = wd;
        end
        m_sys = m_sys + 1;
    endtask

    function automatic logic [31:0] exp_rd(int i);
        if (!re || addr[31:4] != BASE[31:4]) return 32'h0;
        case (addr[3:2])
            2'd0:    return m_th[i];
            2'd1:    return m_tl[i];
            2'd2:    return {29'b0, m_st[i], m_ie[i], m_en[i]};
`ifdef TIMER_SYSTICK_EN
            default: return m_sys;
`else
            default: return 32'h0;
`endif
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/rd0"}, rd0, exp_rd(0));
        chk({tag, "/rd4"}, rd4, exp_rd(1));
        chk({tag, "/irq0"}, {31'b0, irq0}, {31'b0, m_ie[0] & m_st[0]});
        chk({tag, "/irq4"}, {31'b0, irq4}, {31'b0, m_ie[1] & m_st[1]});
    endtask

    task automatic cyc();
        step_model();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wd = d; we = 1'b1; re = 1'b0;
        cyc();
        we = 1'b0;
        check_all("wr");
    endtask

    task automatic expect_rd(input string tag, input int i, input logic [31:0] a, input logic [31:0] exp);
        addr = a; re = 1'b1; we = 1'b0;
        #1;
        chk(tag, (i == 0) ? rd0 : rd4, exp);
        check_all(tag);
        re = 1'b0;
    endtask

    task automatic rand_cycle(input bit win_writes);
        int r;
        r = $urandom_range(0, 9);
        if (r < 6)      addr = BASE + $urandom_range(0, 15);
        else if (r < 8) addr = BASE + $urandom_range(16, 65535);
        else            addr = $urandom;
        we = 1'($urandom_range(0, 1));
        re = 1'($urandom_range(0, 1));
        wd = $urandom;
        if (addr[3:2] == 2'd1 && $urandom_range(0, 1) == 1) wd = 32'hFFFFFFFF - $urandom_range(0, 3);
        if (!win_writes && addr[31:4] == BASE[31:4] && addr[3:2] != 2'd3) we = 1'b0;
        #1;
        check_all("rnd");
        cyc();
        we = 1'b0; re = 1'b0;
    endtask

    initial begin
        reset = 1'b1; addr = 0; wd = 0; we = 0; re = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();

        expect_rd("rst_th", 0, BASE, 32'h0);
        expect_rd("rst_tl", 0, BASE + 4, 32'h0);
        expect_rd("rst_tcon", 0, BASE + 8, 32'h0);
        expect_rd("rst_0c", 0, BASE + 12, 32'h0);
        expect_rd("rst_out", 0, BASE + 16, 32'h0);
        chk("rst_irq", {31'b0, irq0}, 32'h0);

        wr(BASE, 32'hFFFFFFF0);
        wr(BASE + 4, 32'hFFFFFFFD);
        wr(BASE + 8, 32'h3);
        expect_rd("tl_fd", 0, BASE + 4, 32'hFFFFFFFD);
        cyc();
        expect_rd("tl_fe", 0, BASE + 4, 32'hFFFFFFFE);
        cyc();
        expect_rd("tl_ff", 0, BASE + 4, 32'hFFFFFFFF);
        chk("irq_pre", {31'b0, irq0}, 32'h0);
        cyc();
        expect_rd("tl_reload", 0, BASE + 4, 32'hFFFFFFF0);
        expect_rd("tcon_7", 0, BASE + 8, 32'h7);
        chk("irq_up", {31'b0, irq0}, 32'h1);

        for (int n = 0; n < 100; n++) begin
            rand_cycle(1'b0);
            chk("irq_hold", {31'b0, irq0}, 32'h1);
        end

        wr(BASE + 8, 32'h3);
        chk("irq_clr", {31'b0, irq0}, 32'h0);
        expect_rd("tl_run", 0, BASE + 4, 32'hFFFFFFF5);
        repeat (10) begin
            cyc();
            check_all("run");
        end
        chk("irq_n16_pre", {31'b0, irq0}, 32'h0);
        cyc();
        chk("irq_n16", {31'b0, irq0}, 32'h1);
        expect_rd("tl_n16", 0, BASE + 4, 32'hFFFFFFF0);

        wr(BASE + 8, 32'h0);
        wr(BASE, 32'h1234);
        wr(BASE + 4, 32'hFFFFFFFF);
        wr(BASE + 8, 32'h3);
        wr(BASE + 8, 32'h2);
        expect_rd("col_tcon", 0, BASE + 8, 32'h6);
        chk("col_irq", {31'b0, irq0}, 32'h1);
        expect_rd("col_tl", 0, BASE + 4, 32'h1234);
        repeat (3) cyc();
        expect_rd("col_stop", 0, BASE + 4, 32'h1234);

        wr(BASE + 8, 32'h4);
        chk("ie_off", {31'b0, irq0}, 32'h0);
        expect_rd("ie_off_tcon", 0, BASE + 8, 32'h4);
        wr(BASE + 8, 32'h6);
        chk("ie_on", {31'b0, irq0}, 32'h1);

        wr(BASE + 8, 32'h0);
        wr(BASE + 4, 32'hFFFFFFFF);
        wr(BASE + 8, 32'h3);
        wr(BASE + 4, 32'h5);
        expect_rd("tlwr_tl", 0, BASE + 4, 32'h5);
        expect_rd("tlwr_tcon", 0, BASE + 8, 32'h3);
        cyc();
        expect_rd("tlwr_inc", 0, BASE + 4, 32'h6);

        wr(BASE + 8, 32'h0);
        wr(BASE, 32'h100);
        wr(BASE + 4, 32'hFFFFFFFF);
        wr(BASE + 8, 32'h3);
        wr(BASE, 32'hAAAA);
        expect_rd("thwr_tl", 0, BASE + 4, 32'h100);
        expect_rd("thwr_th", 0, BASE, 32'hAAAA);
        expect_rd("thwr_tcon", 0, BASE + 8, 32'h7);

        wr(BASE + 8, 32'h0);
        wr(BASE + 4, 32'hFFFFFFFE);
        wr(BASE + 8, 32'h1);
        cyc();
        cyc();
        expect_rd("noie_tl", 0, BASE + 4, 32'hAAAA);
        expect_rd("noie_tcon", 0, BASE + 8, 32'h1);
        chk("noie_irq", {31'b0, irq0}, 32'h0);

        wr(BASE + 8, 32'h0);
        wr(BASE + 4, 32'h0);
        wr(BASE + 8, 32'h1);
        repeat (8) cyc();
        expect_rd("ps4_tl", 1, BASE + 4, 32'h2);
        expect_rd("ps1_tl", 0, BASE + 4, 32'h8);

        for (int n = 0; n < 400; n++) rand_cycle(1'b1);

        wr(BASE + 8, 32'h7);
        chk("ar_irq0_up", {31'b0, irq0}, 32'h1);
        chk("ar_irq4_up", {31'b0, irq4}, 32'h1);
        #20 reset = 1'b1;
        #1;
        chk("ar_irq0", {31'b0, irq0}, 32'h0);
        chk("ar_irq4", {31'b0, irq4}, 32'h0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        repeat (3) cyc();
        expect_rd("ar_tl0", 0, BASE + 4, 32'h0);
        expect_rd("ar_tl4", 1, BASE + 4, 32'h0);
        expect_rd("ar_tcon", 0, BASE + 8, 32'h0);
        expect_rd("ar_0c", 0, BASE + 12, exp_rd(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
